if_prefetch_queue: RTL
======================

IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 Parameter DATA_W, default 32, width of IR, PC and InstrAddr fields.
REQ-002 Parameter PPCCB_W, default 34, width of the prediction/branch-info field.
REQ-003 Parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Rst  input  1  reset, synchronous, active-high.
REQ-006 Flush  input  1  discard all entries (branch mispredict / pipe flush).
REQ-007 PushValid  input  1  fetch logic presents an entry.
REQ-008 PushIR, PushPC, PushInstrAddr  input  DATA_W each  fetched instruction, next PC, instruction address.
REQ-009 PushPPCCB  input  PPCCB_W  predicted-PC and counter bits for the entry.
REQ-010 PushReady  output  1  queue can accept a push this cycle.
REQ-011 PopStall  input  1  decode stalled; head entry not consumed.
REQ-012 IR, PC, InstrAddr  output  DATA_W each  head entry fields.
REQ-013 PPCCB  output  PPCCB_W  head entry prediction field.
REQ-014 PCSource  output  1  head entry valid (queue not empty).
REQ-015 Count  output  $clog2(DEPTH+1)  current occupancy.
REQ-016 Full, Empty  output  1 each  occupancy == DEPTH, occupancy == 0.

Function
REQ-017 Storage: DEPTH-entry circular buffer, entry = {InstrAddr, PPCCB, PC, IR}; write/read pointers $clog2(DEPTH) bits, wrap modulo DEPTH with no gap.
REQ-018 PushReady = !Full (combinational from registered state; no dependence on PopStall).
REQ-019 Push occurs iff PushValid && PushReady && !Flush; entry written at write pointer, pointer +1.
REQ-020 Pop occurs iff !Empty && !PopStall && !Flush; read pointer +1.
REQ-021 Simultaneous push and pop: both performed, Count unchanged; when Count==1 the pushed entry becomes head next cycle.
REQ-022 Push attempted while Full: not accepted, no state change, stored entries intact.
REQ-023 Pop with Empty: no state change; pointers never underflow.
REQ-024 Count next = Count + push - pop; never exceeds DEPTH nor drops below 0.
REQ-025 Outputs combinational from head entry; zero on all of IR, PC, InstrAddr, PPCCB and PCSource=0 while Empty or Rst.
REQ-026 No fall-through: entry pushed in cycle N visible at outputs earliest in cycle N+1.
REQ-027 Flush: next cycle pointers equal, Count=0, Empty=1, PCSource=0; push and pop in the flush cycle discarded; PushReady=1 the cycle after.
REQ-028 Flush has priority over push and pop; Rst has priority over Flush.

Reset
REQ-029 Rst sampled at rising edge: pointers=0, Count=0, Empty=1, Full=0, PushReady=1, PCSource=0, all data outputs 0.
REQ-030 Rst asserted mid-operation discards all entries identically to REQ-029; storage contents need not be cleared.
REQ-031 First push accepted in the first cycle after Rst deasserts.

Verification
REQ-032 Post-reset: Rst 1 cycle -> Empty=1, Count=0, PushReady=1, PCSource=0, IR=0.
REQ-033 Fill DEPTH=4 with IR 0x11,0x22,0x33,0x44, PopStall=1 -> Full=1, PushReady=0; fifth push 0x55 rejected; release PopStall -> IR 0x11,0x22,0x33,0x44 in order, then Empty=1.
REQ-034 Count=1 (head 0xA0), push 0xB0 and pop same cycle -> Count=1, IR=0xB0 next cycle.
REQ-035 Count=3, Flush with PushValid=1 -> next cycle Count=0, PCSource=0, pushed entry absent.
REQ-036 Wrap: 10 push/pop pairs with increasing PC values -> output order matches push order, no entry lost or duplicated, Count never > 4.
REQ-037 Rst asserted with Count=2 and Flush=1 -> REQ-029 values next cycle.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - instruction-fetch prefetch queue between fetch and decode
module if_prefetch_queue #(
    parameter int DATA_W  = 32,
    parameter int PPCCB_W = 34,
    parameter int DEPTH   = 4
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Flush,
    input  logic                       PushValid,
    input  logic [DATA_W-1:0]          PushIR,
    input  logic [DATA_W-1:0]          PushPC,
    input  logic [DATA_W-1:0]          PushInstrAddr,
    input  logic [PPCCB_W-1:0]         PushPPCCB,
    output logic                       PushReady,
    input  logic                       PopStall,
    output logic [DATA_W-1:0]          IR,
    output logic [DATA_W-1:0]          PC,
    output logic [DATA_W-1:0]          InstrAddr,
    output logic [PPCCB_W-1:0]         PPCCB,
    output logic                       PCSource,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Full,
    output logic                       Empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0]  r_ir_mem   [DEPTH];
    logic [DATA_W-1:0]  r_pc_mem   [DEPTH];
    logic [DATA_W-1:0]  r_addr_mem [DEPTH];
    logic [PPCCB_W-1:0] r_ppccb_mem[DEPTH];

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_head_valid;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Flush suppresses both sides; pointers wrap naturally since DEPTH is a power of two
    assign w_push = PushValid && !w_full && !Flush;
    assign w_pop  = !w_empty && !PopStall && !Flush;

    always_ff @(posedge Clk) begin
        if (Rst || Flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; occupancy alone decides what is visible
    always_ff @(posedge Clk) begin
        if (!Rst && w_push) begin
            r_ir_mem[r_wptr]    <= PushIR;
            r_pc_mem[r_wptr]    <= PushPC;
            r_addr_mem[r_wptr]  <= PushInstrAddr;
            r_ppccb_mem[r_wptr] <= PushPPCCB;
        end
    end

    assign w_head_valid = !w_empty && !Rst;

    assign IR        = w_head_valid ? r_ir_mem[r_rptr]    : '0;
    assign PC        = w_head_valid ? r_pc_mem[r_rptr]    : '0;
    assign InstrAddr = w_head_valid ? r_addr_mem[r_rptr]  : '0;
    assign PPCCB     = w_head_valid ? r_ppccb_mem[r_rptr] : '0;
    assign PCSource  = w_head_valid;

    assign PushReady = !w_full;
    assign Full      = w_full;
    assign Empty     = w_empty;
    assign Count     = r_count;
endmodule
